// File: rtl/pc_sequencer.sv
// Program counter sequencer: fetch / execute / PC-commit, with halt/resume
// and a single-level interrupt (EPC save, ISR vector, return).
module pc_sequencer #(
  parameter int unsigned          WIDTH      = 32,
  parameter logic [WIDTH-1:0]     RESET_ADDR = '0,
  parameter logic [WIDTH-1:0]     ISR_ADDR   = WIDTH'(1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] prox_pc,
  input  logic             imem_ack,
  input  logic             exec_done,
  input  logic             halt,
  input  logic             reti,
  input  logic             ei,
  input  logic             di,
  input  logic             irq,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] epc,
  output logic             imem_req,
  output logic             inst_valid,
  output logic             irq_ack,
  output logic             int_en,
  output logic             halted
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_TRAP   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             int_en_q, int_en_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_ADDR;
      epc_q    <= '0;
      int_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      int_en_q <= int_en_d;
    end
  end

  // Exactly one action per completed instruction; halt outranks interrupt
  // entry, which in turn swallows any reti/ei/di retiring in the same cycle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    epc_d    = epc_q;
    int_en_d = int_en_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (exec_done) begin
          if (halt) begin
            pc_d    = prox_pc;
            state_d = S_HALTED;
          end else if (irq && int_en_q) begin
            epc_d   = prox_pc;
            state_d = S_TRAP;
          end else if (reti) begin
            pc_d     = epc_q;
            int_en_d = 1'b1;
            state_d  = S_FETCH;
          end else begin
            pc_d    = prox_pc;
            state_d = S_FETCH;
            if (di)      int_en_d = 1'b0;
            else if (ei) int_en_d = 1'b1;
          end
        end
      end
      S_TRAP: begin
        pc_d     = ISR_ADDR;
        int_en_d = 1'b0;
        state_d  = S_FETCH;
      end
      S_HALTED: begin
        if (resume) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are gated by reset so nothing is requested while it is held.
  assign imem_req   = reset && (state_q == S_FETCH);
  assign inst_valid = reset && (state_q == S_FETCH) && imem_ack;
  assign irq_ack    = reset && (state_q == S_TRAP);
  assign halted     = reset && (state_q == S_HALTED);

  assign pc     = pc_q;
  assign epc    = epc_q;
  assign int_en = int_en_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: sequencing, fetch stall,
// interrupt entry/return, ei/di, halt/resume and async reset.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] prox_pc;
  logic        imem_ack, exec_done, halt, reti, ei, di, irq, resume;
  logic [31:0] pc, epc;
  logic        imem_req, inst_valid, irq_ack, int_en, halted;

  int checks   = 0;
  int failures = 0;

  pc_sequencer #(.WIDTH(32), .RESET_ADDR(32'd0), .ISR_ADDR(32'd1)) dut (
    .clock      (clock),
    .reset      (reset),
    .prox_pc    (prox_pc),
    .imem_ack   (imem_ack),
    .exec_done  (exec_done),
    .halt       (halt),
    .reti       (reti),
    .ei         (ei),
    .di         (di),
    .irq        (irq),
    .resume     (resume),
    .pc         (pc),
    .epc        (epc),
    .imem_req   (imem_req),
    .inst_valid (inst_valid),
    .irq_ack    (irq_ack),
    .int_en     (int_en),
    .halted     (halted)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One instruction: fetch with immediate ack, execute with immediate done.
  task automatic run_instr(input logic [31:0] nxt, input logic h, input logic rt,
                           input logic e, input logic d, input logic q);
    imem_ack = 1'b1;
    step();
    imem_ack  = 1'b0;
    exec_done = 1'b1;
    prox_pc   = nxt;
    halt = h; reti = rt; ei = e; di = d; irq = q;
    step();
    exec_done = 1'b0;
    halt = 1'b0; reti = 1'b0; ei = 1'b0; di = 1'b0;
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    prox_pc = 32'h0; imem_ack = 0; exec_done = 0; halt = 0; reti = 0;
    ei = 0; di = 0; irq = 0; resume = 0;
    step();
    step();
    checks++; if (pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", pc); end
    checks++; if (epc !== 32'd0) begin failures++; $display("FAIL reset_epc got=%0h exp=0", epc); end
    checks++; if (int_en !== 1'b0) begin failures++; $display("FAIL reset_int_en got=%b exp=0", int_en); end
    checks++; if ({imem_req, inst_valid, irq_ack, halted} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes got=%b exp=0000", {imem_req, inst_valid, irq_ack, halted});
    end
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL reset_release_req got=%b exp=1", imem_req); end
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 4; k++) begin
      checks++; if (pc !== 32'(k)) begin failures++; $display("FAIL seq_pc[%0d] got=%0h exp=%0h", k, pc, k); end
      imem_ack = 1'b1;
      #1;
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL seq_inst_valid[%0d] got=%b exp=1", k, inst_valid); end
      step();
      imem_ack = 1'b0;
      #1;
      checks++; if ({imem_req, inst_valid} !== 2'b00) begin
        failures++; $display("FAIL seq_exec_strobes[%0d] got=%b exp=00", k, {imem_req, inst_valid});
      end
      exec_done = 1'b1;
      prox_pc   = 32'(k + 1);
      step();
      exec_done = 1'b0;
    end
    checks++; if (pc !== 32'd4) begin failures++; $display("FAIL seq_pc_end got=%0h exp=4", pc); end
  endtask

  task automatic test_stall();
    imem_ack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if ({imem_req, inst_valid} !== 2'b10 || pc !== 32'd4) begin
        failures++; $display("FAIL stall[%0d] got req/iv=%b pc=%0h exp=10 pc=4", c, {imem_req, inst_valid}, pc);
      end
      step();
    end
    imem_ack = 1'b1;
    #1;
    checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL stall_ack_iv got=%b exp=1", inst_valid); end
    step();
    imem_ack = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_exec_req got=%b exp=0", imem_req); end
    exec_done = 1'b1; prox_pc = 32'd5;
    step();
    exec_done = 1'b0;
    checks++; if (pc !== 32'd5) begin failures++; $display("FAIL stall_commit_pc got=%0h exp=5", pc); end
  endtask

  task automatic test_interrupt();
    apply_reset();
    run_instr(32'd1, 0, 0, 0, 0, 0);
    run_instr(32'd2, 0, 0, 0, 0, 0);
    // ei retires with irq already high: enable only applies to the next one
    run_instr(32'd3, 0, 0, 1, 0, 1);
    checks++; if (pc !== 32'd3 || int_en !== 1'b1 || irq_ack !== 1'b0 || imem_req !== 1'b1) begin
      failures++; $display("FAIL ei_no_trap got pc=%0h int_en=%b ack=%b req=%b exp pc=3 1 0 1", pc, int_en, irq_ack, imem_req);
    end
    run_instr(32'd9, 0, 0, 0, 0, 1);
    checks++; if (irq_ack !== 1'b1 || epc !== 32'd9 || pc !== 32'd3) begin
      failures++; $display("FAIL trap_entry got ack=%b epc=%0h pc=%0h exp ack=1 epc=9 pc=3", irq_ack, epc, pc);
    end
    irq = 1'b0;
    step();
    checks++; if (pc !== 32'd1 || int_en !== 1'b0 || irq_ack !== 1'b0 || imem_req !== 1'b1) begin
      failures++; $display("FAIL isr_vector got pc=%0h int_en=%b ack=%b req=%b exp pc=1 0 0 1", pc, int_en, irq_ack, imem_req);
    end
    run_instr(32'd2, 0, 1, 0, 0, 0);
    checks++; if (pc !== 32'd9 || int_en !== 1'b1) begin
      failures++; $display("FAIL reti got pc=%0h int_en=%b exp pc=9 int_en=1", pc, int_en);
    end
  endtask

  task automatic test_di();
    run_instr(32'd10, 0, 0, 1, 1, 0);
    checks++; if (pc !== 32'd10 || int_en !== 1'b0) begin
      failures++; $display("FAIL ei_di_both got pc=%0h int_en=%b exp pc=a int_en=0", pc, int_en);
    end
    run_instr(32'd11, 0, 0, 0, 0, 1);
    checks++; if (pc !== 32'd11 || irq_ack !== 1'b0 || imem_req !== 1'b1 || epc !== 32'd9) begin
      failures++; $display("FAIL irq_masked got pc=%0h ack=%b req=%b epc=%0h exp pc=b 0 1 epc=9", pc, irq_ack, imem_req, epc);
    end
    irq = 1'b0;
  endtask

  task automatic test_halt();
    run_instr(32'd7, 1, 0, 0, 0, 0);
    checks++; if (halted !== 1'b1 || pc !== 32'd7 || imem_req !== 1'b0) begin
      failures++; $display("FAIL halt got halted=%b pc=%0h req=%b exp 1 7 0", halted, pc, imem_req);
    end
    irq = 1'b1;
    step();
    step();
    checks++; if (halted !== 1'b1 || irq_ack !== 1'b0 || imem_req !== 1'b0) begin
      failures++; $display("FAIL halt_hold got halted=%b ack=%b req=%b exp 1 0 0", halted, irq_ack, imem_req);
    end
    irq = 1'b0;
    resume = 1'b1;
    step();
    resume = 1'b0;
    #1;
    checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || pc !== 32'd7) begin
      failures++; $display("FAIL resume got halted=%b req=%b pc=%0h exp 0 1 7", halted, imem_req, pc);
    end
  endtask

  task automatic test_back_to_back();
    run_instr(32'd8, 0, 0, 1, 0, 0);
    run_instr(32'd12, 1, 0, 0, 0, 1);
    checks++; if (halted !== 1'b1 || pc !== 32'd12 || epc !== 32'd9 || irq_ack !== 1'b0) begin
      failures++; $display("FAIL halt_vs_irq got halted=%b pc=%0h epc=%0h ack=%b exp 1 c 9 0", halted, pc, epc, irq_ack);
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    // irq and reti retiring together: interrupt entry wins, reti is dropped
    run_instr(32'd13, 0, 1, 0, 0, 1);
    irq = 1'b0;
    checks++; if (irq_ack !== 1'b1 || epc !== 32'd13) begin
      failures++; $display("FAIL irq_vs_reti got ack=%b epc=%0h exp 1 d", irq_ack, epc);
    end
    step();
    checks++; if (pc !== 32'd1 || int_en !== 1'b0) begin
      failures++; $display("FAIL irq_vs_reti_vec got pc=%0h int_en=%b exp 1 0", pc, int_en);
    end
  endtask

  task automatic test_async_reset();
    run_instr(32'h20, 0, 0, 1, 0, 0);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    exec_done = 1'b1;
    prox_pc = 32'h21;
    #2;
    checks++; if (pc !== 32'h20 || int_en !== 1'b1) begin
      failures++; $display("FAIL pre_reset got pc=%0h int_en=%b exp 20 1", pc, int_en);
    end
    reset = 1'b0;
    #1;
    checks++; if (pc !== 32'd0 || int_en !== 1'b0 || epc !== 32'd0 || imem_req !== 1'b0) begin
      failures++; $display("FAIL async_reset got pc=%0h int_en=%b epc=%0h req=%b exp 0 0 0 0", pc, int_en, epc, imem_req);
    end
    step();
    exec_done = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || pc !== 32'd0) begin
      failures++; $display("FAIL async_reset_fetch got req=%b pc=%0h exp 1 0", imem_req, pc);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_interrupt();
    test_di();
    test_halt();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
